// File: rtl/mux_rr_packet_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Wrap-around increment of a round-robin pointer in the range 0..n-1.
  function automatic int unsigned rr_next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/mux_rr_packet_arbiter_picker.sv
// Combinational round-robin picker: first set request at or above start, wrapping around.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] win_idx,
  output logic          any_grant
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic           found;

  // The upper copy of the request vector supplies the wrapped-around candidates.
  always_comb begin
    dbl     = {req, req};
    masked  = dbl & ({(2*N){1'b1}} << start);
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && masked[i]) begin
        found   = 1'b1;
        win_idx = SW'(i % N);
      end
    end
    grant = '0;
    if (found) grant[win_idx] = 1'b1;
    any_grant = found;
  end

endmodule

// File: rtl/mux_rr_packet_arbiter.sv
// N:1 round-robin packet arbiter with grant locking and one registered output stage.
// state  | meaning
// IDLE   | no packet open, round-robin pick among valid requesters
// LOCKED | packet open, only lock_id may transfer until its last beat
module mux_rr_packet_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [SRC_W-1:0]       out_src
);

  arb_state_t       state;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] lock_id;
  logic [SRC_W-1:0] start_ptr;

  logic [N_REQ-1:0] pick_grant;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;

  logic             load_en;
  logic             take;
  logic [SRC_W-1:0] take_idx;
  logic [WIDTH-1:0] beat [N_REQ];

  assign load_en   = !out_valid || out_ready;
  assign start_ptr = SRC_W'(rr_next_ptr(32'(last_grant), 32'(N_REQ)));

  rr_priority_picker #(
    .N  (N_REQ),
    .SW (SRC_W)
  ) u_picker (
    .req       (req_valid),
    .start     (start_ptr),
    .grant     (pick_grant),
    .win_idx   (pick_idx),
    .any_grant (pick_any)
  );

  always_comb begin
    for (int k = 0; k < N_REQ; k++) beat[k] = req_data[k*WIDTH +: WIDTH];
  end

  // While locked the owner sees ready even without valid, so a gap in its packet is a bubble.
  always_comb begin
    req_ready = '0;
    take      = 1'b0;
    take_idx  = pick_idx;
    if (load_en) begin
      if (state == IDLE) begin
        if (pick_any) begin
          req_ready = pick_grant;
          take      = 1'b1;
        end
      end else begin
        req_ready[lock_id] = 1'b1;
        take               = req_valid[lock_id];
        take_idx           = lock_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(N_REQ - 1);
      lock_id    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= '0;
    end else if (take) begin
      out_valid  <= 1'b1;
      out_data   <= beat[take_idx];
      out_last   <= req_last[take_idx];
      out_src    <= take_idx;
      last_grant <= take_idx;
      lock_id    <= take_idx;
      state      <= req_last[take_idx] ? IDLE : LOCKED;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_packet_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic vs a model.
module tb_mux_rr_packet_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;

  mux_rr_packet_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: rotation pointer, open packet owner, and the output register contents.
  int           m_lg;
  bit           m_locked;
  int           m_lid;
  bit           m_ov;
  logic [W-1:0] m_od;
  bit           m_ol;
  int           m_os;
  logic [N-1:0] last_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                        input logic [7:0] d1, input logic [7:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_reset();
    m_lg = N - 1; m_locked = 0; m_lid = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
  endtask

  function automatic logic [N-1:0] exp_ready(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (m_ov && !out_ready) return r;
    if (m_locked) begin
      r[m_lid] = 1'b1;
      return r;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_lg + k) % N;
      if (v[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d,
                     input logic ordy);
    logic [N-1:0] er;
    int k;
    req_valid = v; req_last = l; req_data = d; out_ready = ordy;
    #1;
    er = exp_ready(v);
    last_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    k = -1;
    for (int i = 0; i < N; i++) if (v[i] && er[i]) k = i;
    if (k >= 0) begin
      m_ov = 1; m_od = d[k*W +: W]; m_ol = l[k]; m_os = k;
      m_lg = k; m_locked = !l[k]; m_lid = k;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_src", 32'(out_src), 32'(m_os));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_src [5];
    exp_src = '{0, 1, 2, 3, 0};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);

    // Full-load rotation with single-beat packets.
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b1111, pk(8'h33, 8'h22, 8'h11, 8'h00), 1'b1);
      chk("rr_grant", 32'(last_rdy), 32'(4'b0001 << exp_src[i]));
      chk("rr_src", 32'(out_src), 32'(exp_src[i]));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Three-beat packet from requester 2 blocks 0 and 1.
    cyc(4'b0010, 4'b0010, pk(8'h00, 8'h00, 8'h01, 8'h00), 1'b1);
    cyc(4'b0111, 4'b0000, pk(8'h00, 8'hA0, 8'h11, 8'h10), 1'b1);
    chk("pkt_rdy0", 32'(last_rdy), 32'(4'b0100));
    chk("pkt_d0", 32'(out_data), 32'h A0);
    cyc(4'b0111, 4'b0000, pk(8'h00, 8'hA1, 8'h11, 8'h10), 1'b1);
    chk("pkt_rdy1", 32'(last_rdy), 32'(4'b0100));
    chk("pkt_d1", 32'(out_data), 32'h A1);
    cyc(4'b0111, 4'b0100, pk(8'h00, 8'hA2, 8'h11, 8'h10), 1'b1);
    chk("pkt_rdy2", 32'(last_rdy), 32'(4'b0100));
    chk("pkt_d2", 32'(out_data), 32'h A2);
    chk("pkt_last", 32'(out_last), 32'd1);
    chk("pkt_src", 32'(out_src), 32'd2);
    cyc(4'b1011, 4'b1011, pk(8'h33, 8'h00, 8'h11, 8'h10), 1'b1);
    chk("pkt_next", 32'(last_rdy), 32'(4'b1000));

    // Output backpressure holds the register and gates every ready.
    cyc(4'b0010, 4'b0010, pk(8'h00, 8'h00, 8'h55, 8'h00), 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1111, 4'b1111, pk(8'h33, 8'h22, 8'h11, 8'h00), 1'b0);
      chk("bp_rdy", 32'(last_rdy), 32'd0);
      chk("bp_data", 32'(out_data), 32'h55);
      chk("bp_src", 32'(out_src), 32'd1);
    end
    cyc(4'b1111, 4'b1111, pk(8'h33, 8'h22, 8'h11, 8'h00), 1'b1);
    chk("bp_release", 32'(last_rdy), 32'(4'b0100));

    // Locked requester 1 pauses; requester 3 must wait.
    cyc(4'b0010, 4'b0000, pk(8'h00, 8'h00, 8'h70, 8'h00), 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(4'b1000, 4'b1000, pk(8'h33, 8'h00, 8'h00, 8'h00), 1'b1);
      chk("bub_rdy3", 32'(last_rdy[3]), 32'd0);
      chk("bub_valid", 32'(out_valid), 32'd0);
    end
    cyc(4'b1010, 4'b0010, pk(8'h33, 8'h00, 8'h77, 8'h00), 1'b1);
    chk("bub_resume", 32'(last_rdy), 32'(4'b0010));
    chk("bub_data", 32'(out_data), 32'h77);
    cyc(4'b1000, 4'b1000, pk(8'h33, 8'h00, 8'h00, 8'h00), 1'b1);
    chk("bub_after", 32'(last_rdy), 32'(4'b1000));

    // Asynchronous reset in the middle of a packet owned by requester 1.
    cyc(4'b0010, 4'b0000, pk(8'h00, 8'h00, 8'h90, 8'h00), 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b0101, 4'b0101, pk(8'h00, 8'h22, 8'h00, 8'h44), 1'b1);
    chk("arst_first", 32'(last_rdy), 32'(4'b0001));
    cyc(4'b0100, 4'b0100, pk(8'h00, 8'h22, 8'h00, 8'h00), 1'b1);
    chk("arst_second", 32'(last_rdy), 32'(4'b0100));

    // Idle stretch then a lone request from 3.
    for (int i = 0; i < 5; i++) cyc(4'b0000, 4'b0000, '0, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    cyc(4'b1000, 4'b1000, pk(8'h3C, 8'h00, 8'h00, 8'h00), 1'b1);
    chk("idle_rdy", 32'(last_rdy), 32'(4'b1000));
    chk("idle_src", 32'(out_src), 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      if (i % 700 == 699) do_reset();
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 99) < 60);
        l[k] = ($urandom_range(0, 99) < 40);
      end
      cyc(v, l, N*W'($urandom), ($urandom_range(0, 99) < 75));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_packet_arbiter.md
Name: mux_rr_packet_arbiter

Overview:
- Shares one output channel (the select/data path of an N:1 mux) between N_REQ requesters using valid/ready handshakes.
- Round-robin arbitration with packet locking: once a requester wins, it keeps the grant until its beat flagged last is accepted.
- One registered output stage drives the shared channel toward downstream logic.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width per beat
SRC_W, $clog2(N_REQ), width of the source index (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester beat valid
req_last  input  N_REQ  per-requester end-of-packet flag, qualified by req_valid
req_data  input  N_REQ*WIDTH  packed beats, requester k at [k*WIDTH +: WIDTH]
req_ready  output  N_REQ  per-requester accept, at most one bit high (one-hot or zero)
out_valid  output  1  output register holds a beat
out_ready  input  1  downstream accepts the beat
out_data  output  WIDTH  registered beat
out_last  output  1  registered last flag
out_src  output  SRC_W  index of requester that produced out_data

Behaviour:
- Reset values (async, immediate): out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, last_grant=N_REQ-1. After reset, requester 0 has top priority.
- load_en = !out_valid || out_ready. The output register can accept a new beat when it is empty or being drained this cycle, so back-to-back beats sustain full throughput.
- FSM states: IDLE (no packet open) and LOCKED (packet open for requester lock_id).
- IDLE grant selection:
  - If load_en and any req_valid, pick the first set bit searching from last_grant+1 upward with wrap-around (k = N_REQ-1 wraps to 0).
  - Assert req_ready[winner]=1 combinationally.
  - On the clock edge: capture data/last/src, set out_valid=1, set last_grant=winner.
  - If req_last[winner]=0, go to LOCKED with lock_id=winner; otherwise stay in IDLE.
- LOCKED:
  - req_ready[lock_id] = load_en. All other ready bits are 0, whatever their valids.
  - Each accepted beat is captured as in IDLE.
  - An accepted beat with last=1 returns to IDLE.
  - If req_valid[lock_id]=0, no beat loads; the grant is held and other requesters stay blocked (bubble).
- If load_en=0, all req_ready=0 and the register holds its contents stable.
- When out_valid && out_ready && no beat is loading, out_valid clears at the next edge. out_data/out_last/out_src keep their stale values.
- Handshake rules:
  - A beat transfers when req_valid[k] && req_ready[k].
  - req_ready may depend on req_valid (arbitration). req_valid must not depend on req_ready.
  - Output contract: while out_valid && !out_ready, out_data, out_last and out_src are stable.
- Latency: one cycle from input acceptance to out_valid.
- Fairness: a requester with continuous valid waits at most N_REQ-1 packets before it is granted.
- Single-beat packet (valid and last together in IDLE): granted, no lock.
- Reset mid-packet: the lock is dropped and the output beat is discarded. Arbitration resumes from requester 0.
- last_grant updates only on an accepted beat, never on an idle cycle.

Decomposition:
- Package mux_arb_pkg holds:
  - typedef arb_state_t enum {IDLE, LOCKED}
  - function rr_next_ptr(ptr, N) for wrap-around increment
- One sub-module, rr_priority_picker, is purely combinational:
  - inputs: request vector, start pointer
  - outputs: one-hot grant, winner index, any_grant
  - implementation: double-width masked find-first
- Top level holds the FSM, last_grant, lock_id and the output register.

Test Plan:
- Reset then req_valid=4'b1111, all last=1, out_ready=1 -> grants to 0,1,2,3,0 on consecutive cycles; out_src sequence 0,1,2,3,0 one cycle later; out_valid continuously 1.
- Requester 2 sends 3-beat packet (D=8'hA0,A1,A2, last on A2) while req 0 and 1 valid -> out_data A0,A1,A2 contiguous with out_src=2; req_ready[0], req_ready[1] stay 0 until A2 is accepted; next grant goes to requester 3 if valid, else 0.
- Output backpressure: load beat 8'h55 from req 1, hold out_ready=0 for 4 cycles -> out_data=55, out_src=1 stable; all req_ready=0; on out_ready=1, next beat loads the same cycle with no bubble.
- Locked requester 1 drops req_valid for 2 cycles mid-packet, req 3 valid -> no beats output (out_valid falls after drain); req_ready[3]=0 throughout; packet resumes from req 1 when its valid returns.
- Assert rst asynchronously mid-packet (between clock edges) -> out_valid=0 immediately; after release, req 0 and 2 valid -> requester 0 granted first, req 2 not blocked by old lock.
- No requests for 5 cycles with out_ready=1 -> out_valid=0 and last_grant unchanged; then only req 3 valid -> granted the next cycle, out_src=3.
